mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer that shares one unified instruction/data memory between the fetch path and the load/store path of the RV32I core. It accepts one request at a time from either requester, drives a variable-latency memory handshake, and returns aligned, sign-/zero-extended load data or fetched instructions. It sits between the core (PC/fetch and load/store address generation) and the memory macro. It replaces the separate instruction and data memories and lets the core stall on a busy memory.

---
 rtl/mem_arbiter_pkg.sv | 44 ++++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_lsu_align.sv | 43 ++++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
// Lane/byte-enable and access-legality rules live here.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    D_BUSY,
    D_ERR
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_of(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic bad_acc(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ill;
    logic mis;
    ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    mis = ((f3[1:0] == 2'b01) && a[0])
       || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return ill || mis;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side signals of the arbiter.
// slave is the arbiter's view, master the environment's.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_funct3;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_funct3, d_wdata,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_funct3, d_wdata,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_lsu_align.sv
// Combinational byte-lane steering for loads and stores:
// byte enables, store replication, load extraction/extension.
module lsu_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic [31:0] sh;
  logic        sx;

  assign sh = rdata_i >> {addr_i, 3'b000};
  assign sx = ~funct3_i[2];

  always_comb begin
    be_o    = be_of(funct3_i, addr_i);
    bad_o   = bad_acc(funct3_i, addr_i);
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sh[7] & sx}}, sh[7:0]};
      end
      2'b01: begin
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sh[15] & sx}}, sh[15:0]};
      end
      default: begin
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs load/store,
// with starvation guard on fetch and registered returns.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAXW = WW'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              if_gnt, d_gnt;
  logic              force_if;

  logic        idle;
  logic [2:0]  la_f3;
  logic [1:0]  la_a;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_bad;
  logic        unused_ok;

  // Grant-time checks use live inputs; load extraction uses the captured fields.
  assign idle  = (state_q == IDLE);
  assign la_f3 = idle ? bus.d_funct3 : f3_q;
  assign la_a  = idle ? bus.d_addr[1:0] : off_q;
  assign unused_ok = ^bus.if_addr[1:0];

  lsu_align u_align (
    .funct3_i (la_f3),
    .addr_i   (la_a),
    .wdata_i  (bus.d_wdata),
    .rdata_i  (bus.mem_rdata),
    .be_o     (la_be),
    .wdata_o  (la_wdata),
    .rdata_o  (la_rdata),
    .bad_o    (la_bad)
  );

  assign force_if = bus.if_req && (wait_q == MAXW);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !force_if) begin
          d_gnt       = 1'b1;
          if (bus.if_req) wait_d = wait_q + 1'b1;
          f3_d        = bus.d_funct3;
          off_d       = bus.d_addr[1:0];
          mem_we_d    = bus.d_we;
          mem_addr_d  = {bus.d_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = la_be;
          mem_wdata_d = bus.d_we ? la_wdata : 32'd0;
          if (la_bad) begin
            state_d = D_ERR;
          end else begin
            state_d   = D_BUSY;
            mem_req_d = 1'b1;
          end
        end else if (bus.if_req) begin
          if_gnt      = 1'b1;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {bus.if_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = 4'b1111;
          mem_wdata_d = 32'd0;
          state_d     = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
          state_d     = IDLE;
        end
      end
      D_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_we_q ? 32'd0 : la_rdata;
          state_d    = IDLE;
        end
      end
      D_ERR: begin
        d_rvalid_d = 1'b1;
        d_err_d    = 1'b1;
        d_rdata_d  = 32'd0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses,
// error path, reset abandonment and fetch starvation guard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clock;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    bit          is_d;
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .MAX_WAIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Return monitor: every rvalid must match the oldest scoreboard entry.
  always @(negedge clock) begin
    if (bus.if_rvalid || bus.d_rvalid) begin
      chk("rv_sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rv_d", 32'(bus.d_rvalid), 32'(e.is_d));
        chk("rv_if", 32'(bus.if_rvalid), 32'(!e.is_d));
        chk("rv_cyc", 32'(cyc), 32'(e.cyc));
        if (e.is_d) begin
          chk("d_rdata", bus.d_rdata, e.rd);
          chk("d_err", 32'(bus.d_err), 32'(e.err));
        end else begin
          chk("if_rdata", bus.if_rdata, e.rd);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
    chk({tag, "_d_err"}, 32'(bus.d_err), 32'd0);
  endtask

  task automatic access(
    input string       tag,
    input bit          is_d,
    input bit          we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] mrd,
    input int          lat,
    input logic [31:0] e_addr,
    input logic [3:0]  e_be,
    input logic [31:0] e_wd,
    input logic [31:0] e_rd,
    input bit          e_err
  );
    int   t;
    exp_t e;
    @(negedge clock);
    if (is_d) begin
      bus.d_req    = 1'b1;
      bus.d_we     = we;
      bus.d_funct3 = f3;
      bus.d_addr   = addr;
      bus.d_wdata  = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    #1;
    t = 0;
    while (!(is_d ? bus.d_gnt : bus.if_gnt) && t < 20) begin
      @(negedge clock);
      #1;
      t++;
    end
    chk({tag, "_gnt_lat"}, 32'(t), 32'd0);
    e.is_d = is_d;
    e.rd   = e_rd;
    e.err  = e_err;
    e.cyc  = cyc + (e_err ? 2 : lat + 1);
    if (t < 20) sb.push_back(e);
    @(negedge clock);
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    if (t >= 20) return;
    if (e_err) begin
      chk({tag, "_no_req1"}, 32'(bus.mem_req), 32'd0);
      @(negedge clock);
      chk({tag, "_no_req2"}, 32'(bus.mem_req), 32'd0);
    end else begin
      chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, "_we"}, 32'(bus.mem_we), 32'(we));
      chk({tag, "_addr"}, bus.mem_addr, e_addr);
      chk({tag, "_be"}, 32'(bus.mem_be), 32'(e_be));
      if (we) chk({tag, "_wdata"}, bus.mem_wdata, e_wd);
      repeat (lat - 1) @(negedge clock);
      chk({tag, "_req_held"}, 32'(bus.mem_req), 32'd1);
      chk({tag, "_addr_held"}, bus.mem_addr, e_addr);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mrd;
      @(negedge clock);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [9:0] order;
    int       t;
    exp_t     e;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_funct3  = 3'd0;
    bus.d_wdata   = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(negedge clock);
    check_zero("rst0");
    reset = 1'b0;

    access("if100", 0, 0, F3_W, 32'h100, 0, 32'h0050_0093, 3,
           32'h100, 4'hF, 0, 32'h0050_0093, 0);
    access("if103", 0, 0, F3_W, 32'h103, 0, 32'h1111_2222, 1,
           32'h100, 4'hF, 0, 32'h1111_2222, 0);
    access("sh206", 1, 1, F3_H, 32'h206, 32'h1234_ABCD, 32'h0, 2,
           32'h204, 4'b1100, 32'hABCD_ABCD, 32'h0, 0);
    access("sb201", 1, 1, F3_B, 32'h201, 32'h1234_5678, 32'h0, 1,
           32'h200, 4'b0010, 32'h7878_7878, 32'h0, 0);
    access("sw208", 1, 1, F3_W, 32'h208, 32'hCAFE_F00D, 32'h0, 2,
           32'h208, 4'hF, 32'hCAFE_F00D, 32'h0, 0);
    access("lw101", 1, 0, F3_W, 32'h101, 0, 0, 1,
           0, 0, 0, 32'h0, 1);
    access("f3011", 1, 0, 3'b011, 32'h100, 0, 0, 1,
           0, 0, 0, 32'h0, 1);
    access("lh201", 1, 0, F3_H, 32'h201, 0, 0, 1,
           0, 0, 0, 32'h0, 1);
    access("lb203", 1, 0, F3_B, 32'h203, 0, 32'h80FF_0000, 2,
           32'h200, 4'b1000, 0, 32'hFFFF_FF80, 0);
    access("lbu203", 1, 0, F3_BU, 32'h203, 0, 32'h80FF_0000, 1,
           32'h200, 4'b1000, 0, 32'h0000_0080, 0);
    access("lhu202", 1, 0, F3_HU, 32'h202, 0, 32'h80FF_0000, 1,
           32'h200, 4'b1100, 0, 32'h0000_80FF, 0);
    access("lh202", 1, 0, F3_H, 32'h202, 0, 32'h80FF_0000, 1,
           32'h200, 4'b1100, 0, 32'hFFFF_80FF, 0);
    access("lw200", 1, 0, F3_W, 32'h200, 0, 32'h80FF_1234, 3,
           32'h200, 4'hF, 0, 32'h80FF_1234, 0);

    // Abandon an in-flight load with reset; the late ack must be dropped.
    @(negedge clock);
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = F3_W;
    bus.d_addr   = 32'h400;
    #1;
    chk("rst_mid_gnt", 32'(bus.d_gnt), 32'd1);
    @(negedge clock);
    bus.d_req = 1'b0;
    chk("rst_mid_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_zero("rst_mid");
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_d", 32'(bus.d_rvalid), 32'd0);
      chk("late_ack_if", 32'(bus.if_rvalid), 32'd0);
      chk("late_ack_req", 32'(bus.mem_req), 32'd0);
      @(negedge clock);
    end

    // Both requesters held; fetch must break through every MAX_WAIT data wins.
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = F3_W;
    bus.d_addr   = 32'h300;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h180;
    order = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      t = 0;
      while (!(bus.d_gnt || bus.if_gnt) && t < 20) begin
        @(negedge clock);
        #1;
        t++;
      end
      chk("fair_gnt_lat", 32'(t), 32'd0);
      if (t >= 20) break;
      chk("fair_one_gnt", 32'(bus.d_gnt && bus.if_gnt), 32'd0);
      order[i] = bus.if_gnt;
      e.is_d = bus.d_gnt;
      e.rd   = 32'hC0DE_0000 | 32'(i);
      e.err  = 0;
      e.cyc  = cyc + 2;
      sb.push_back(e);
      @(negedge clock);
      if (i == 9) begin
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
      end
      chk("fair_req", 32'(bus.mem_req), 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hC0DE_0000 | 32'(i);
      @(negedge clock);
      bus.mem_ack = 1'b0;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    chk("fair_order", 32'(order), 32'h210);
    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
